// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module  : seq_detector_param
// Brief   : Parametrised Moore serial pattern detector with KMP transition
//           table, overlap / non-overlap modes and a saturating match counter.
// Revision: 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seq_in,
  input  logic             overlap,
  input  logic             clr_count,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int C_SW  = $clog2(PAT_LEN + 1);
  localparam int C_ENT = 2 * (PAT_LEN + 1);

  typedef logic [C_SW-1:0] state_t;
  localparam state_t S_0    = '0;
  localparam state_t S_DONE = state_t'(PAT_LEN);

  // Entry {k, bit}: longest pattern prefix that is a suffix of (prefix_k, bit).
  function automatic logic [C_ENT*C_SW-1:0] build_table();
    logic [C_ENT*C_SW-1:0] tab;
    int   best;
    int   pos;
    logic ok;
    logic sbit;
    tab = '0;
    for (int k = 0; k <= PAT_LEN; k++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        for (int j = 1; j <= PAT_LEN; j++) begin
          if (j <= k + 1) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
              pos  = k + 1 - j + i;
              sbit = (pos == k) ? b[0] : PATTERN[PAT_LEN-1-pos];
              if (sbit != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
            end
            if (ok) best = j;
          end
        end
        tab[(2*k+b)*C_SW +: C_SW] = C_SW'(best);
      end
    end
    return tab;
  endfunction

  localparam logic [C_ENT*C_SW-1:0] C_TAB = build_table();

  logic [C_SW-1:0] w_tab [C_ENT];

  generate
    for (genvar g = 0; g < C_ENT; g++) begin : g_tab
      assign w_tab[g] = C_TAB[g*C_SW +: C_SW];
    end
  endgenerate

  state_t           r_state;
  state_t           w_row;
  state_t           w_next;
  logic             w_hit;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_0;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  // Non-overlapping mode re-reads the bit after a full match as if from S_0.
  always_comb begin
    w_row = r_state;
    if ((r_state == S_DONE) && !overlap) begin
      w_row = S_0;
    end
    w_next    = w_tab[{w_row, seq_in}];
    w_hit     = en && (w_next == S_DONE);
    w_cnt_inc = r_count + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clr_count) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (w_hit && !(&r_count)) begin
      r_count <= w_cnt_inc;
      r_sat   <= &w_cnt_inc;
    end
  end

  assign detected    = (r_state == S_DONE);
  assign match_count = r_count;
  assign count_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_detector_param
// Brief   : Directed and random checks of seq_detector_param against a
//           window-based reference model (pattern 1101 and a 1-bit pattern).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic       seq_in;
  logic       overlap;
  logic       clr_count;

  logic       det_a;
  logic [7:0] cnt_a;
  logic       sat_a;
  logic       det_s;
  logic [1:0] cnt_s;
  logic       sat_s;
  logic       det_1;
  logic [7:0] cnt_1;
  logic       sat_1;

  int tests = 0;
  int fails = 0;
  string phase = "init";

  bit win_a[$];
  bit win_1[$];
  int m_a, m_1;
  int c_a, c_s, c_1;

  seq_detector_param u_dut (
    .clk(clk), .reset(reset), .en(en), .seq_in(seq_in), .overlap(overlap),
    .clr_count(clr_count), .detected(det_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .seq_in(seq_in), .overlap(overlap),
    .clr_count(clr_count), .detected(det_s), .match_count(cnt_s), .count_sat(sat_s)
  );

  seq_detector_param #(.PAT_LEN(1), .PATTERN(1'b1), .CNT_W(8)) u_one (
    .clk(clk), .reset(reset), .en(en), .seq_in(seq_in), .overlap(overlap),
    .clr_count(clr_count), .detected(det_1), .match_count(cnt_1), .count_sat(sat_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Longest pattern prefix that ends the received window.
  function automatic int mstate(input bit q[$], input logic [15:0] pat, input int len);
    int best = 0;
    for (int j = 1; j <= len; j++) begin
      if (j <= q.size()) begin
        bit ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          if (q[q.size()-j+i] != pat[len-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk({phase, "_det_a"}, 32'(det_a), 32'(m_a == 4));
    chk({phase, "_cnt_a"}, 32'(cnt_a), 32'(c_a));
    chk({phase, "_sat_a"}, 32'(sat_a), 32'(c_a == 255));
    chk({phase, "_det_s"}, 32'(det_s), 32'(m_a == 4));
    chk({phase, "_cnt_s"}, 32'(cnt_s), 32'(c_s));
    chk({phase, "_sat_s"}, 32'(sat_s), 32'(c_s == 3));
    chk({phase, "_det_1"}, 32'(det_1), 32'(m_1 == 1));
    chk({phase, "_cnt_1"}, 32'(cnt_1), 32'(c_1));
    chk({phase, "_sat_1"}, 32'(sat_1), 32'(c_1 == 255));
  endtask

  task automatic model_edge();
    bit hit_a = 1'b0;
    bit hit_1 = 1'b0;
    if (en) begin
      if (m_a == 4 && !overlap) win_a.delete();
      win_a.push_back(seq_in);
      if (win_a.size() > 4) void'(win_a.pop_front());
      m_a   = mstate(win_a, 16'hD, 4);
      hit_a = (m_a == 4);
      if (m_1 == 1 && !overlap) win_1.delete();
      win_1.push_back(seq_in);
      if (win_1.size() > 1) void'(win_1.pop_front());
      m_1   = mstate(win_1, 16'h1, 1);
      hit_1 = (m_1 == 1);
    end
    if (clr_count) begin
      c_a = 0; c_s = 0; c_1 = 0;
    end else begin
      if (hit_a && c_a < 255) c_a++;
      if (hit_a && c_s < 3)   c_s++;
      if (hit_1 && c_1 < 255) c_1++;
    end
  endtask

  task automatic step(input logic e, input logic b, input logic o, input logic c);
    en = e; seq_in = b; overlap = o; clr_count = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic model_reset();
    win_a.delete(); win_1.delete();
    m_a = 0; m_1 = 0; c_a = 0; c_s = 0; c_1 = 0;
  endtask

  // Reset is raised mid-cycle so its asynchronous effect is visible at once.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input logic o);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], o, 1'b0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; seq_in = 1'b0; overlap = 1'b1; clr_count = 1'b0;
    model_reset();
    #1;
    phase = "reset";
    check_all();
    @(negedge clk);
    reset = 1'b0;

    phase = "t1";
    feed(16'b1101, 4, 1'b1);
    chk("t1_det", 32'(det_a), 32'd1);
    chk("t1_cnt", 32'(cnt_a), 32'd1);

    phase = "t2_ov";
    feed(16'b101, 3, 1'b1);
    chk("t2_ov_cnt", 32'(cnt_a), 32'd2);

    do_reset();
    phase = "t2_nov";
    feed(16'b1101101, 7, 1'b0);
    chk("t2_nov_cnt", 32'(cnt_a), 32'd1);

    do_reset();
    phase = "t3";
    feed(16'b11101, 5, 1'b1);
    chk("t3_det", 32'(det_a), 32'd1);

    do_reset();
    phase = "t4";
    feed(16'b11, 2, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
    feed(16'b01, 2, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_det_hold", 32'(det_a), 32'd1);
    chk("t4_cnt_hold", 32'(cnt_a), 32'd1);

    do_reset();
    phase = "t5";
    repeat (5) feed(16'b1101, 4, 1'b0);
    chk("t5_cnt_s", 32'(cnt_s), 32'd3);
    chk("t5_sat_s", 32'(sat_s), 32'd1);
    chk("t5_cnt_a", 32'(cnt_a), 32'd5);
    feed(16'b110, 3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_clr_cnt", 32'(cnt_a), 32'd0);
    chk("t5_clr_sat", 32'(sat_s), 32'd0);

    phase = "t6";
    feed(16'b110, 3, 1'b1);
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_no_det", 32'(det_a), 32'd0);
    feed(16'b1101, 4, 1'b1);
    chk("t6_det", 32'(det_a), 32'd1);

    phase = "p1";
    feed(16'b1111, 4, 1'b1);
    feed(16'b0111, 4, 1'b0);

    phase = "rand";
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
             1'($urandom_range(1)), 1'($urandom_range(24) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
